mem_write_checker: RTL and testbench

//  Synthesisable self-checking monitor for processor test benches. Samples the data-memory

---
 rtl/mem_write_checker_if.sv | 45 ++++
 rtl/mem_write_checker.sv | 155 +++++++++++++++
 tb/tb_mem_write_checker.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_write_checker_if.sv
// Stimulus and verdict signals of the write checker, grouped for one port.
// Slave modport is the checker's view; master is the driving bench/harness.
interface mem_write_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_EXP  = 8,
    parameter int CNT_W  = 16
);
    localparam int IW = $clog2(N_EXP);
    localparam int NW = IW + 1;

    logic              tbl_we;
    logic [IW-1:0]     tbl_idx;
    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_data;
    logic [NW-1:0]     n_exp;
    logic              start;
    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;

    logic              done;
    logic              pass;
    logic              fail;
    logic              timed_out;
    logic [NW-1:0]     wr_idx;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  mism_count;
    logic [ADDR_W-1:0] err_addr;
    logic [DATA_W-1:0] err_data;

    modport slave (
        input  tbl_we, tbl_idx, tbl_addr, tbl_data, n_exp, start,
               memwrite, dataadr, writedata,
        output done, pass, fail, timed_out, wr_idx, cycle_count,
               mism_count, err_addr, err_data
    );

    modport master (
        output tbl_we, tbl_idx, tbl_addr, tbl_data, n_exp, start,
               memwrite, dataadr, writedata,
        input  done, pass, fail, timed_out, wr_idx, cycle_count,
               mism_count, err_addr, err_data
    );
endinterface

// File: rtl/mem_write_checker.sv
// Checks a CPU's data-memory writes, in order, against a loaded table of expected writes.
// Verdict flags rise one edge after the deciding sample; passive monitor, never stalls the CPU.
module mem_write_checker #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int N_EXP       = 8,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 16,
    parameter int STRICT      = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    mem_write_checker_if.slave bus
);
    localparam int IW = $clog2(N_EXP);
    localparam int NW = IW + 1;
    localparam logic [NW-1:0]    N_MAX    = NW'(N_EXP);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     n_exp_q, n_exp_d;
    logic [NW-1:0]     wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  mism_q, mism_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [DATA_W-1:0] err_data_q, err_data_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              to_q, to_d;

    logic [ADDR_W-1:0] tbl_addr_q [N_EXP];
    logic [DATA_W-1:0] tbl_data_q [N_EXP];

    logic              hit;
    logic              verdict;
    logic [NW-1:0]     wr_idx_inc;
    logic [NW-1:0]     n_clamp;

    // Expected table has no reset so one load serves many reruns.
    always_ff @(posedge clk_i) begin
        if (bus.tbl_we && state_q == S_IDLE) begin
            tbl_addr_q[bus.tbl_idx] <= bus.tbl_addr;
            tbl_data_q[bus.tbl_idx] <= bus.tbl_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            n_exp_q    <= '0;
            wr_idx_q   <= '0;
            cyc_q      <= '0;
            mism_q     <= '0;
            err_addr_q <= '0;
            err_data_q <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_exp_q    <= n_exp_d;
            wr_idx_q   <= wr_idx_d;
            cyc_q      <= cyc_d;
            mism_q     <= mism_d;
            err_addr_q <= err_addr_d;
            err_data_q <= err_data_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            to_q       <= to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_exp_d    = n_exp_q;
        wr_idx_d   = wr_idx_q;
        cyc_d      = cyc_q;
        mism_d     = mism_q;
        err_addr_d = err_addr_q;
        err_data_d = err_data_q;
        verdict    = 1'b0;
        wr_idx_inc = wr_idx_q + 1'b1;
        n_clamp    = (bus.n_exp > N_MAX) ? N_MAX : bus.n_exp;
        hit        = bus.memwrite
                     && bus.dataadr   == tbl_addr_q[wr_idx_q[IW-1:0]]
                     && bus.writedata == tbl_data_q[wr_idx_q[IW-1:0]];

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    n_exp_d    = n_clamp;
                    wr_idx_d   = '0;
                    cyc_d      = '0;
                    mism_d     = '0;
                    err_addr_d = '0;
                    err_data_d = '0;
                    state_d    = (n_clamp == '0) ? S_PASS : S_RUN;
                end
            end
            S_RUN: begin
                if (cyc_q != CNT_SAT) begin
                    cyc_d = cyc_q + 1'b1;
                end
                if (hit) begin
                    wr_idx_d = wr_idx_inc;
                    if (wr_idx_inc == n_exp_q) begin
                        state_d = S_PASS;
                        verdict = 1'b1;
                    end
                end else if (bus.memwrite) begin
                    if (STRICT != 0) begin
                        state_d    = S_FAIL;
                        verdict    = 1'b1;
                        err_addr_d = bus.dataadr;
                        err_data_d = bus.writedata;
                    end else if (mism_q != CNT_SAT) begin
                        mism_d = mism_q + 1'b1;
                    end
                end
                // A deciding write on the last allowed cycle beats the timeout.
                if (!verdict && cyc_q == CYC_LAST) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: ;
        endcase

        done_d = (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
        pass_d = (state_d == S_PASS);
        fail_d = (state_d == S_FAIL) || (state_d == S_TIMEOUT);
        to_d   = (state_d == S_TIMEOUT);
    end

    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.fail        = fail_q;
    assign bus.timed_out   = to_q;
    assign bus.wr_idx      = wr_idx_q;
    assign bus.cycle_count = cyc_q;
    assign bus.mism_count  = mism_q;
    assign bus.err_addr    = err_addr_q;
    assign bus.err_data    = err_data_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// Drives a strict and a lax checker with identical stimulus and compares both to a write-list model.
module tb_mem_write_checker;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NE = 8;
    localparam int TO = 20;
    localparam int CW = 16;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] t_a [NE];
    logic [31:0] t_d [NE];
    logic        s_we [32];
    logic [31:0] s_a  [32];
    logic [31:0] s_d  [32];
    int          fd_s;
    int          fd_l;

    mem_write_checker_if #(.ADDR_W(AW), .DATA_W(DW), .N_EXP(NE), .CNT_W(CW)) if_s ();
    mem_write_checker_if #(.ADDR_W(AW), .DATA_W(DW), .N_EXP(NE), .CNT_W(CW)) if_l ();

    assign if_l.tbl_we    = if_s.tbl_we;
    assign if_l.tbl_idx   = if_s.tbl_idx;
    assign if_l.tbl_addr  = if_s.tbl_addr;
    assign if_l.tbl_data  = if_s.tbl_data;
    assign if_l.n_exp     = if_s.n_exp;
    assign if_l.start     = if_s.start;
    assign if_l.memwrite  = if_s.memwrite;
    assign if_l.dataadr   = if_s.dataadr;
    assign if_l.writedata = if_s.writedata;

    mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .N_EXP(NE), .TIMEOUT_CYC(TO),
                        .CNT_W(CW), .STRICT(1)) u_strict (
        .clk_i(clk), .reset_i(reset), .bus(if_s.slave)
    );
    mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .N_EXP(NE), .TIMEOUT_CYC(TO),
                        .CNT_W(CW), .STRICT(0)) u_lax (
        .clk_i(clk), .reset_i(reset), .bus(if_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_stim();
        for (int i = 0; i < 32; i++) begin
            s_we[i] = 1'b0;
            s_a[i]  = '0;
            s_d[i]  = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        if_s.tbl_we   = 1'b1;
        if_s.tbl_idx  = 3'(i);
        if_s.tbl_addr = a;
        if_s.tbl_data = d;
        @(negedge clk);
        if_s.tbl_we = 1'b0;
        t_a[i] = a;
        t_d[i] = d;
    endtask

    // Pulse start, then replay s_* one entry per RUN cycle; fd_* = first negedge index with done.
    task automatic run(input int n);
        @(negedge clk);
        if_s.start = 1'b1;
        if_s.n_exp = 4'(n);
        fd_s = -1;
        fd_l = -1;
        for (int k = 0; k < TO + 4; k++) begin
            @(negedge clk);
            if_s.start = 1'b0;
            if (fd_s < 0 && if_s.done === 1'b1) fd_s = k;
            if (fd_l < 0 && if_l.done === 1'b1) fd_l = k;
            if_s.memwrite  = s_we[k];
            if_s.dataadr   = s_a[k];
            if_s.writedata = s_d[k];
        end
        if_s.memwrite = 1'b0;
    endtask

    // Walk the write list: v = deciding cycle, fl = {pass,fail,timed_out}.
    task automatic model(input int n, input bit strict, output int v, output logic [2:0] fl,
                         output int idx, output int mism, output logic [63:0] err);
        int nn;
        nn   = (n > NE) ? NE : n;
        v    = -1;
        fl   = 3'b000;
        idx  = 0;
        mism = 0;
        err  = '0;
        if (nn == 0) begin
            fl = 3'b100;
            return;
        end
        for (int c = 0; c < TO; c++) begin
            if (s_we[c]) begin
                if (s_a[c] == t_a[idx] && s_d[c] == t_d[idx]) begin
                    idx++;
                    if (idx == nn) begin
                        fl = 3'b100;
                        v  = c;
                        return;
                    end
                end else if (strict) begin
                    fl  = 3'b010;
                    v   = c;
                    err = {s_a[c], s_d[c]};
                    return;
                end else begin
                    mism++;
                end
            end
            if (c == TO - 1) begin
                fl = 3'b011;
                v  = c;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({if_s.done, if_s.pass, if_s.fail, if_s.timed_out, if_s.wr_idx, if_s.cycle_count,
             if_s.mism_count, if_s.err_addr, if_s.err_data} !== '0) begin
            errors++;
            $display("FAIL reset_strict outputs not all zero done=%b wr_idx=%0d", if_s.done, if_s.wr_idx);
        end
        checks++;
        if ({if_l.done, if_l.pass, if_l.fail, if_l.timed_out, if_l.wr_idx, if_l.cycle_count,
             if_l.mism_count, if_l.err_addr, if_l.err_data} !== '0) begin
            errors++;
            $display("FAIL reset_lax outputs not all zero done=%b wr_idx=%0d", if_l.done, if_l.wr_idx);
        end
    endtask

    task automatic test_single_match();
        load(0, 32'd84, 32'd7);
        clear_stim();
        s_we[12] = 1'b1; s_a[12] = 32'd84; s_d[12] = 32'd7;
        run(1);
        checks++;
        if (fd_s !== 13) begin errors++; $display("FAIL single done_time got %0d exp 13", fd_s); end
        checks++;
        if ({if_s.pass, if_s.fail, if_s.wr_idx} !== {1'b1, 1'b0, 4'd1}) begin
            errors++; $display("FAIL single pass/fail/wr_idx got %b/%b/%0d exp 1/0/1", if_s.pass, if_s.fail, if_s.wr_idx);
        end
        checks++;
        if (if_s.cycle_count !== 16'd13) begin errors++; $display("FAIL single cycle_count got %0d exp 13", if_s.cycle_count); end
    endtask

    task automatic test_mismatch();
        do_reset();
        load(0, 32'd80, 32'd7);
        load(1, 32'd84, 32'd7);
        clear_stim();
        s_we[0] = 1'b1; s_a[0] = 32'd80; s_d[0] = 32'd6;
        s_we[2] = 1'b1; s_a[2] = 32'd80; s_d[2] = 32'd7;
        s_we[4] = 1'b1; s_a[4] = 32'd84; s_d[4] = 32'd7;
        run(2);
        checks++;
        if (fd_s !== 1 || {if_s.pass, if_s.fail, if_s.timed_out} !== 3'b010) begin
            errors++; $display("FAIL strict_mism done_time=%0d flags=%b exp 1 010", fd_s, {if_s.pass, if_s.fail, if_s.timed_out});
        end
        checks++;
        if ({if_s.err_addr, if_s.err_data, if_s.wr_idx} !== {32'd80, 32'd6, 4'd0}) begin
            errors++; $display("FAIL strict_err got %0d:%0d wr_idx %0d exp 80:6 0", if_s.err_addr, if_s.err_data, if_s.wr_idx);
        end
        checks++;
        if (fd_l !== 5 || {if_l.pass, if_l.fail} !== 2'b10) begin
            errors++; $display("FAIL lax_pass done_time=%0d pass=%b exp 5 1", fd_l, if_l.pass);
        end
        checks++;
        if ({if_l.mism_count, if_l.wr_idx} !== {16'd1, 4'd2}) begin
            errors++; $display("FAIL lax_counts mism=%0d wr_idx=%0d exp 1 2", if_l.mism_count, if_l.wr_idx);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        clear_stim();
        run(2);
        checks++;
        if (fd_s !== TO || {if_s.done, if_s.pass, if_s.fail, if_s.timed_out} !== 4'b1011) begin
            errors++; $display("FAIL timeout_strict done_time=%0d flags=%b exp %0d 1011", fd_s,
                               {if_s.done, if_s.pass, if_s.fail, if_s.timed_out}, TO);
        end
        checks++;
        if (fd_l !== TO || if_l.timed_out !== 1'b1 || if_l.cycle_count !== 16'(TO)) begin
            errors++; $display("FAIL timeout_lax done_time=%0d to=%b cyc=%0d exp %0d 1 %0d", fd_l,
                               if_l.timed_out, if_l.cycle_count, TO, TO);
        end
    endtask

    task automatic test_timeout_edge();
        do_reset();
        clear_stim();
        s_we[TO-1] = 1'b1; s_a[TO-1] = 32'd80; s_d[TO-1] = 32'd7;
        run(1);
        checks++;
        if (fd_s !== TO || {if_s.pass, if_s.fail, if_s.timed_out} !== 3'b100 || if_s.wr_idx !== 4'd1) begin
            errors++; $display("FAIL last_cycle_match done_time=%0d flags=%b wr_idx=%0d exp %0d 100 1", fd_s,
                               {if_s.pass, if_s.fail, if_s.timed_out}, if_s.wr_idx, TO);
        end
        do_reset();
        clear_stim();
        run(0);
        checks++;
        if (fd_s !== 0 || if_s.pass !== 1'b1 || if_s.cycle_count !== 16'd0) begin
            errors++; $display("FAIL n_exp_zero done_time=%0d pass=%b cyc=%0d exp 0 1 0", fd_s, if_s.pass, if_s.cycle_count);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        @(negedge clk);
        if_s.start = 1'b1;
        if_s.n_exp = 4'd2;
        @(negedge clk);
        if_s.start = 1'b0;
        if_s.memwrite = 1'b1; if_s.dataadr = 32'd80; if_s.writedata = 32'd7;
        @(negedge clk);
        if_s.memwrite = 1'b0;
        checks++;
        if (if_s.wr_idx !== 4'd1) begin errors++; $display("FAIL midrun_match wr_idx got %0d exp 1", if_s.wr_idx); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({if_s.done, if_s.wr_idx, if_s.cycle_count} !== '0) begin
            errors++; $display("FAIL midrun_reset done=%b wr_idx=%0d cyc=%0d exp 0", if_s.done, if_s.wr_idx, if_s.cycle_count);
        end
        clear_stim();
        s_we[0] = 1'b1; s_a[0] = 32'd80; s_d[0] = 32'd7;
        s_we[1] = 1'b1; s_a[1] = 32'd84; s_d[1] = 32'd7;
        run(2);
        checks++;
        if (fd_s !== 2 || if_s.pass !== 1'b1 || if_s.wr_idx !== 4'd2) begin
            errors++; $display("FAIL rerun_after_reset done_time=%0d pass=%b wr_idx=%0d exp 2 1 2", fd_s, if_s.pass, if_s.wr_idx);
        end
    endtask

    task automatic test_load_with_start();
        do_reset();
        @(negedge clk);
        if_s.tbl_we = 1'b1; if_s.tbl_idx = 3'd0; if_s.tbl_addr = 32'h100; if_s.tbl_data = 32'h55;
        if_s.start = 1'b1; if_s.n_exp = 4'd1;
        t_a[0] = 32'h100; t_d[0] = 32'h55;
        @(negedge clk);
        if_s.tbl_we = 1'b0; if_s.start = 1'b0;
        if_s.memwrite = 1'b1; if_s.dataadr = 32'h100; if_s.writedata = 32'h55;
        @(negedge clk);
        if_s.memwrite = 1'b0;
        checks++;
        if ({if_s.done, if_s.pass, if_s.wr_idx} !== {1'b1, 1'b1, 4'd1}) begin
            errors++; $display("FAIL load_with_start done=%b pass=%b wr_idx=%0d exp 1 1 1", if_s.done, if_s.pass, if_s.wr_idx);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        for (int i = 0; i < NE; i++) load(i, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i));
        clear_stim();
        for (int i = 0; i < NE; i++) begin
            s_we[i] = 1'b1; s_a[i] = t_a[i]; s_d[i] = t_d[i];
        end
        run(12);
        checks++;
        if (fd_s !== NE || if_s.pass !== 1'b1 || if_s.wr_idx !== 4'(NE)) begin
            errors++; $display("FAIL n_exp_clamp done_time=%0d pass=%b wr_idx=%0d exp %0d 1 %0d", fd_s, if_s.pass, if_s.wr_idx, NE, NE);
        end
    endtask

    task automatic test_random();
        int          n, p, v_s, v_l, idx_s, idx_l, mm_s, mm_l;
        logic [2:0]  fl_s, fl_l;
        logic [63:0] err_s, err_l;
        for (int it = 0; it < 30; it++) begin
            do_reset();
            for (int i = 0; i < NE; i++) load(i, 32'(4 * $urandom_range(3)), 32'($urandom_range(3)));
            n = $urandom_range(10);
            clear_stim();
            p = 0;
            for (int c = 0; c < TO; c++) begin
                if ($urandom_range(99) < 45) begin
                    s_we[c] = 1'b1;
                    if (p < NE && $urandom_range(99) < 75) begin
                        s_a[c] = t_a[p]; s_d[c] = t_d[p]; p++;
                    end else begin
                        s_a[c] = 32'(4 * $urandom_range(3)); s_d[c] = 32'($urandom_range(3));
                    end
                end
            end
            model(n, 1'b1, v_s, fl_s, idx_s, mm_s, err_s);
            model(n, 1'b0, v_l, fl_l, idx_l, mm_l, err_l);
            run(n);
            checks++;
            if (fd_s !== v_s + 1) begin errors++; $display("FAIL rnd%0d strict done_time got %0d exp %0d", it, fd_s, v_s + 1); end
            checks++;
            if ({if_s.pass, if_s.fail, if_s.timed_out} !== fl_s) begin
                errors++; $display("FAIL rnd%0d strict flags got %b exp %b", it, {if_s.pass, if_s.fail, if_s.timed_out}, fl_s);
            end
            checks++;
            if (if_s.wr_idx !== 4'(idx_s) || if_s.cycle_count !== 16'(v_s + 1)) begin
                errors++; $display("FAIL rnd%0d strict wr_idx/cyc got %0d/%0d exp %0d/%0d", it, if_s.wr_idx, if_s.cycle_count, idx_s, v_s + 1);
            end
            checks++;
            if ({if_s.err_addr, if_s.err_data} !== err_s) begin
                errors++; $display("FAIL rnd%0d strict err got %h exp %h", it, {if_s.err_addr, if_s.err_data}, err_s);
            end
            checks++;
            if (fd_l !== v_l + 1) begin errors++; $display("FAIL rnd%0d lax done_time got %0d exp %0d", it, fd_l, v_l + 1); end
            checks++;
            if ({if_l.pass, if_l.fail, if_l.timed_out} !== fl_l) begin
                errors++; $display("FAIL rnd%0d lax flags got %b exp %b", it, {if_l.pass, if_l.fail, if_l.timed_out}, fl_l);
            end
            checks++;
            if (if_l.wr_idx !== 4'(idx_l) || if_l.cycle_count !== 16'(v_l + 1)) begin
                errors++; $display("FAIL rnd%0d lax wr_idx/cyc got %0d/%0d exp %0d/%0d", it, if_l.wr_idx, if_l.cycle_count, idx_l, v_l + 1);
            end
            checks++;
            if (if_l.mism_count !== 16'(mm_l) || {if_l.err_addr, if_l.err_data} !== 64'd0) begin
                errors++; $display("FAIL rnd%0d lax mism/err got %0d/%h exp %0d/0", it, if_l.mism_count, {if_l.err_addr, if_l.err_data}, mm_l);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        if_s.tbl_we = 1'b0; if_s.tbl_idx = '0; if_s.tbl_addr = '0; if_s.tbl_data = '0;
        if_s.n_exp = '0; if_s.start = 1'b0;
        if_s.memwrite = 1'b0; if_s.dataadr = '0; if_s.writedata = '0;
        for (int i = 0; i < NE; i++) begin
            t_a[i] = '0;
            t_d[i] = '0;
        end
        clear_stim();
        test_reset();
        test_single_match();
        test_mismatch();
        test_timeout();
        test_timeout_edge();
        test_reset_midrun();
        test_load_with_start();
        test_clamp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
